// File: rtl/clock_gate_enable_ctrl.sv
// Enable generation for the CLKGATE_X1 cells of the gated clock domains.
// One FSM per domain (OFF/WAKE/ON/DRAIN) with idle timeout and parent/child nesting.

module clock_gate_enable_ctrl_lane #(
   parameter int IDLE_W    = 8,
   parameter int WAKE_CYC  = 2,
   parameter int DRAIN_CYC = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              go_i,
   input  logic              force_on_i,
   input  logic [IDLE_W-1:0] idle_limit_i,
   input  logic              parent_ok_i,
   input  logic              child_busy_i,
   output logic              gate_en_o,
   output logic              wake_ack_o,
   output logic              on_o,
   output logic              off_o,
   output logic              drain_now_o
);
   localparam int PH_MAX = (WAKE_CYC > DRAIN_CYC) ? WAKE_CYC : DRAIN_CYC;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;

   typedef enum logic [1:0] {OFF, WAKE, ON, DRAIN} state_e;

   state_e            state_q, state_d;
   logic [PH_W-1:0]   ph_q, ph_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              gate_en_q, wake_ack_q;
   logic              timed_out;

   assign timed_out   = (state_q == ON) && (idle_limit_i != '0) && (idle_q >= idle_limit_i)
                        && !force_on_i && !go_i;
   // Drain waits for the child; the parent's lane also uses this to block a child wake.
   assign drain_now_o = timed_out && !child_busy_i;

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      idle_d  = idle_q;
      case (state_q)
         OFF: if (go_i && parent_ok_i) begin
            state_d = WAKE;
            ph_d    = '0;
         end
         WAKE: if (ph_q == PH_W'(WAKE_CYC - 1)) begin
            state_d = ON;
            ph_d    = '0;
         end else begin
            ph_d = ph_q + 1'b1;
         end
         ON: if (drain_now_o) begin
            state_d = DRAIN;
            ph_d    = '0;
         end
         DRAIN: if (go_i) begin
            state_d = ON;
            ph_d    = '0;
         end else if (ph_q == PH_W'(DRAIN_CYC - 1)) begin
            state_d = OFF;
            ph_d    = '0;
         end else begin
            ph_d = ph_q + 1'b1;
         end
         default: state_d = OFF;
      endcase

      if (go_i || state_q != ON)
         idle_d = '0;
      else if (timed_out && child_busy_i)
         idle_d = idle_q;
      else if (idle_q != {IDLE_W{1'b1}})
         idle_d = idle_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= OFF;
         ph_q       <= '0;
         idle_q     <= '0;
         gate_en_q  <= 1'b0;
         wake_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         idle_q     <= idle_d;
         gate_en_q  <= (state_d != OFF);
         wake_ack_q <= (state_q == WAKE) && (state_d == ON);
      end
   end

   assign gate_en_o  = gate_en_q;
   assign wake_ack_o = wake_ack_q;
   assign on_o       = (state_q == ON);
   assign off_o      = (state_q == OFF);
endmodule

module clock_gate_enable_ctrl #(
   parameter int                     NUM_DOMAINS = 5,
   parameter int                     IDLE_W      = 8,
   parameter int                     WAKE_CYC    = 2,
   parameter int                     DRAIN_CYC   = 2,
   parameter logic [NUM_DOMAINS-1:0] NESTED_MASK = 5'b00100
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_DOMAINS-1:0] activity,
   input  logic [NUM_DOMAINS-1:0] wake_req,
   input  logic                   force_on,
   input  logic [IDLE_W-1:0]      idle_limit,
   output logic [NUM_DOMAINS-1:0] gate_en,
   output logic [NUM_DOMAINS-1:0] wake_ack,
   output logic [NUM_DOMAINS-1:0] domain_on
);
   logic [NUM_DOMAINS-1:0] go, parent_ok, child_busy, is_on, is_off, drain_now;

   assign go        = wake_req | activity | {NUM_DOMAINS{force_on}};
   assign domain_on = is_on;

   for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
      // A child may only wake into a parent that is ON and not leaving ON this edge.
      if (i < NUM_DOMAINS - 1 && NESTED_MASK[i]) begin : g_par
         assign parent_ok[i] = is_on[i+1] && !drain_now[i+1];
      end else begin : g_nopar
         assign parent_ok[i] = 1'b1;
      end

      if (i > 0 && NESTED_MASK[i-1]) begin : g_chld
         assign child_busy[i] = !is_off[i-1];
      end else begin : g_nochld
         assign child_busy[i] = 1'b0;
      end

      clock_gate_enable_ctrl_lane #(
         .IDLE_W    (IDLE_W),
         .WAKE_CYC  (WAKE_CYC),
         .DRAIN_CYC (DRAIN_CYC)
      ) u_lane (
         .clk_i        (clk),
         .rst_i        (rst),
         .go_i         (go[i]),
         .force_on_i   (force_on),
         .idle_limit_i (idle_limit),
         .parent_ok_i  (parent_ok[i]),
         .child_busy_i (child_busy[i]),
         .gate_en_o    (gate_en[i]),
         .wake_ack_o   (wake_ack[i]),
         .on_o         (is_on[i]),
         .off_o        (is_off[i]),
         .drain_now_o  (drain_now[i])
      );
   end
endmodule

// File: tb/tb_clock_gate_enable_ctrl.sv
// Directed bench for clock_gate_enable_ctrl: reset, idle timeout, nesting,
// drain abort, force_on / saturation, reset during WAKE and DRAIN.

module tb_clock_gate_enable_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] activity, wake_req;
   logic       force_on;
   logic [7:0] idle_limit;
   logic [4:0] gate_en, wake_ack, domain_on;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clock_gate_enable_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .activity   (activity),
      .wake_req   (wake_req),
      .force_on   (force_on),
      .idle_limit (idle_limit),
      .gate_en    (gate_en),
      .wake_ack   (wake_ack),
      .domain_on  (domain_on)
   );

   // One rising edge; inputs driven and outputs sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_reset();
      rst = 1'b1; activity = '0; wake_req = '0; force_on = 1'b0; idle_limit = '0;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; activity = '1; wake_req = '1; force_on = 1'b1; idle_limit = '1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (gate_en !== 5'b0) begin errors++; $display("FAIL reset_gate_en c=%0d got %b exp 00000", c, gate_en); end
         checks++;
         if (wake_ack !== 5'b0) begin errors++; $display("FAIL reset_wake_ack c=%0d got %b exp 00000", c, wake_ack); end
         checks++;
         if (domain_on !== 5'b0) begin errors++; $display("FAIL reset_domain_on c=%0d got %b exp 00000", c, domain_on); end
      end
      rst = 1'b0; activity = '0; wake_req = '0; force_on = 1'b0; idle_limit = '0;
      step();
      checks++;
      if (gate_en !== 5'b0) begin errors++; $display("FAIL reset_release got %b exp 00000", gate_en); end
   endtask

   task automatic test_wake_idle();
      logic eg, eo, ea;
      quiet_reset();
      idle_limit = 8'd4;
      wake_req[0] = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         step();
         wake_req[0] = 1'b0;
         eg = (k <= 8);
         eo = (k >= 2 && k <= 6);
         ea = (k == 2);
         checks++;
         if (gate_en !== {4'b0, eg}) begin errors++; $display("FAIL t2_gate_en k=%0d got %b exp %b", k, gate_en, {4'b0, eg}); end
         checks++;
         if (domain_on !== {4'b0, eo}) begin errors++; $display("FAIL t2_domain_on k=%0d got %b exp %b", k, domain_on, {4'b0, eo}); end
         checks++;
         if (wake_ack !== {4'b0, ea}) begin errors++; $display("FAIL t2_wake_ack k=%0d got %b exp %b", k, wake_ack, {4'b0, ea}); end
      end
   endtask

   task automatic test_nesting();
      logic [4:0] eg, eo, ea;
      quiet_reset();
      idle_limit = 8'd3;
      wake_req[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (gate_en !== 5'b0) begin errors++; $display("FAIL t3_blocked c=%0d got %b exp 00000", c, gate_en); end
      end
      activity[3] = 1'b1;
      for (int k = 0; k <= 15; k++) begin
         step();
         activity[3] = 1'b0;
         eg = {1'b0, k <= 13, k >= 3 && k <= 10, 2'b0};
         eo = {1'b0, k >= 2 && k <= 11, k >= 5 && k <= 8, 2'b0};
         ea = {1'b0, k == 2, k == 5, 2'b0};
         checks++;
         if (gate_en !== eg) begin errors++; $display("FAIL t3_gate_en k=%0d got %b exp %b", k, gate_en, eg); end
         checks++;
         if (domain_on !== eo) begin errors++; $display("FAIL t3_domain_on k=%0d got %b exp %b", k, domain_on, eo); end
         checks++;
         if (wake_ack !== ea) begin errors++; $display("FAIL t3_wake_ack k=%0d got %b exp %b", k, wake_ack, ea); end
         if (k == 5) wake_req[2] = 1'b0;
      end
   endtask

   task automatic test_drain_abort();
      logic eg, eo, ea;
      quiet_reset();
      idle_limit = 8'd2;
      activity[1] = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         step();
         activity[1] = (k == 5);
         eg = (k <= 10);
         eo = (k >= 2 && k <= 4) || (k >= 6 && k <= 8);
         ea = (k == 2);
         checks++;
         if (gate_en !== {3'b0, eg, 1'b0}) begin errors++; $display("FAIL t4_gate_en k=%0d got %b exp %b", k, gate_en, {3'b0, eg, 1'b0}); end
         checks++;
         if (domain_on !== {3'b0, eo, 1'b0}) begin errors++; $display("FAIL t4_domain_on k=%0d got %b exp %b", k, domain_on, {3'b0, eo, 1'b0}); end
         checks++;
         if (wake_ack !== {3'b0, ea, 1'b0}) begin errors++; $display("FAIL t4_wake_ack k=%0d got %b exp %b", k, wake_ack, {3'b0, ea, 1'b0}); end
      end
   endtask

   task automatic test_force_on_saturate();
      quiet_reset();
      idle_limit = 8'd0;
      force_on = 1'b1;
      step();
      checks++;
      if (gate_en !== 5'b11011) begin errors++; $display("FAIL t5_gate_en_k0 got %b exp 11011", gate_en); end
      step(); step();
      checks++;
      if (domain_on !== 5'b11011) begin errors++; $display("FAIL t5_on_k2 got %b exp 11011", domain_on); end
      checks++;
      if (wake_ack !== 5'b11011) begin errors++; $display("FAIL t5_ack_k2 got %b exp 11011", wake_ack); end
      step();
      checks++;
      if (gate_en !== 5'b11111) begin errors++; $display("FAIL t5_gate_en_k3 got %b exp 11111", gate_en); end
      step(); step();
      checks++;
      if (domain_on !== 5'b11111) begin errors++; $display("FAIL t5_on_k5 got %b exp 11111", domain_on); end
      checks++;
      if (wake_ack !== 5'b00100) begin errors++; $display("FAIL t5_ack_k5 got %b exp 00100", wake_ack); end
      force_on = 1'b0;
      for (int c = 0; c < 300; c++) step();
      checks++;
      if (domain_on !== 5'b11111) begin errors++; $display("FAIL t5_limit0_on got %b exp 11111", domain_on); end
      // A saturated counter (255) meets a limit of 255 at once; a wrapped one would not.
      idle_limit = 8'd255;
      step();
      checks++;
      if (domain_on !== 5'b01000) begin errors++; $display("FAIL t5_sat_drain got %b exp 01000", domain_on); end
      step(); step();
      checks++;
      if (gate_en !== 5'b01000) begin errors++; $display("FAIL t5_children_off got %b exp 01000", gate_en); end
      step();
      checks++;
      if (domain_on !== 5'b00000) begin errors++; $display("FAIL t5_parent_drain got %b exp 00000", domain_on); end
      checks++;
      if (gate_en !== 5'b01000) begin errors++; $display("FAIL t5_parent_draining got %b exp 01000", gate_en); end
      step(); step();
      checks++;
      if (gate_en !== 5'b00000) begin errors++; $display("FAIL t5_parent_off got %b exp 00000", gate_en); end
   endtask

   task automatic test_reset_mid();
      quiet_reset();
      idle_limit = 8'd1;
      activity[0] = 1'b1;
      step();
      activity[0] = 1'b0;
      checks++;
      if (gate_en !== 5'b00001) begin errors++; $display("FAIL t6_wake got %b exp 00001", gate_en); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (gate_en !== 5'b0) begin errors++; $display("FAIL t6_rst_wake got %b exp 00000", gate_en); end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if ((wake_ack | gate_en) !== 5'b0) begin errors++; $display("FAIL t6_no_ack c=%0d got ack %b gate %b exp 0", c, wake_ack, gate_en); end
      end
      activity[4] = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         step();
         activity[4] = 1'b0;
      end
      checks++;
      if ({gate_en[4], domain_on[4]} !== 2'b10) begin errors++; $display("FAIL t6_in_drain got gate %b on %b exp 1 0", gate_en[4], domain_on[4]); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (gate_en !== 5'b0) begin errors++; $display("FAIL t6_rst_drain got %b exp 00000", gate_en); end
      step();
      checks++;
      if ((wake_ack | gate_en | domain_on) !== 5'b0) begin errors++; $display("FAIL t6_after_drain_rst got ack %b gate %b on %b exp 0", wake_ack, gate_en, domain_on); end
   endtask

   initial begin
      rst = 1'b1; activity = '0; wake_req = '0; force_on = 1'b0; idle_limit = '0;
      test_reset();
      test_wake_idle();
      test_nesting();
      test_drain_abort();
      test_force_on_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
